uart_flow_fifo: RTL and testbench
=================================

UART_FLOW_FIFO -- requirements
Module: uart_flow_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning storage entries; power of two, >= 4.
REQ-002 SHALL have parameter CTS_HI, default 12, meaning the fill level at or above which cts_n_out deasserts.
REQ-003 SHALL have parameter CTS_LO, default 4, meaning the fill level at or below which cts_n_out reasserts; CTS_LO < CTS_HI <= DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port byte_in_data, input, 8 bits: byte from the upstream uart_rx.
REQ-007 SHALL have port byte_in_valid, input, 1 bit: upstream byte valid.
REQ-008 SHALL have port byte_in_ready, output, 1 bit: FIFO can accept a byte.
REQ-009 SHALL have port byte_out_data, output, 8 bits: byte to the downstream uart_tx.
REQ-010 SHALL have port byte_out_valid, output, 1 bit: output byte valid.
REQ-011 SHALL have port byte_out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port rts_n_in, input, 1 bit: host RTS, active-low, already synchronised by the instantiator.
REQ-013 SHALL have port cts_n_out, output, 1 bit: CTS to host, active-low, registered.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits: bytes stored, including the output register.

Function
REQ-015 SHALL transfer on the input side when byte_in_valid && byte_in_ready, and on the output side when byte_out_valid && byte_out_ready.
REQ-016 SHALL drive byte_in_ready = (level < DEPTH); the term is combinational from registered state only and independent of byte_out_ready.
REQ-017 SHALL, when full, refuse input even if an output transfer occurs in the same cycle.
REQ-018 SHALL use a registered output stage; a byte accepted into an empty FIFO at cycle N SHALL appear with byte_out_valid=1 at cycle N+1.
REQ-019 SHALL, once byte_out_valid=1, hold byte_out_valid and byte_out_data stable until the output transfer, regardless of rts_n_in.
REQ-020 SHALL preserve byte order with no loss or duplication, including for simultaneous input and output transfers at any level.
REQ-021 SHALL leave level unchanged on simultaneous input and output transfers, increment it on input only, and decrement it on output only.
REQ-022 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-023 SHALL drive cts_n_out to 1 in the cycle after level reaches >= CTS_HI, and to 0 in the cycle after level reaches <= CTS_LO; otherwise it holds its value (hysteresis).
REQ-024 SHALL load the output register with the next stored byte only when the output register is empty or being transferred, and only when rts_n_in=0 in that cycle.

Reset
REQ-025 SHALL, with rst high at a clock edge, clear the pointers and level, set byte_out_valid=0, byte_in_ready=0 during rst, cts_n_out=0, and byte_out_data=8'h00.
REQ-026 SHALL discard all stored bytes on reset asserted mid-operation; the first byte after reset SHALL be the first byte accepted after rst deasserts.
REQ-027 SHALL leave storage RAM contents unreset.

Configuration
REQ-028 SHALL implement the feature selected by the macro UART_FIFO_FLOW_CTRL_EN: when defined, REQ-023 and REQ-024 apply.
REQ-029 SHALL, when UART_FIFO_FLOW_CTRL_EN is undefined, tie cts_n_out constant 0, ignore rts_n_in (REQ-024 loads regardless), keep all ports present, and operate as a plain FIFO.

Verification (DEPTH=16, CTS_HI=12, CTS_LO=4, macro defined unless stated)
REQ-030 SHALL pass: push 0x41 into an empty FIFO at cycle N with byte_out_ready=1 -> byte_out_valid=1, data=0x41 at N+1; level returns to 0 at N+2.
REQ-031 SHALL pass: push 16 bytes 0x00..0x0F with byte_out_ready=0 -> byte_in_ready=0 after the 16th; a 17th byte is not accepted; draining returns 0x00..0x0F in order.
REQ-032 SHALL pass: fill to level 12 -> cts_n_out=1 the next cycle; drain to 5 -> still 1; drain to 4 -> 0 the next cycle.
REQ-033 SHALL pass: with rts_n_in=1 and bytes stored -> the byte in the output register completes its handshake, no further byte is presented; rts_n_in=0 -> the next byte is valid the following cycle.
REQ-034 SHALL pass: continuous push and pop every cycle for 100 bytes across pointer wrap -> level constant, output sequence equals input.
REQ-035 SHALL pass: assert rst at level 7 -> next cycle level=0, byte_out_valid=0, cts_n_out=0; with the macro undefined, cts_n_out=0 at level 16.

Source files
------------

// File: rtl/uart_flow_fifo.sv
// Byte FIFO between uart_rx and uart_tx with a registered output stage and
// RTS/CTS hysteresis flow control, which is enabled by the macro UART_FIFO_FLOW_CTRL_EN.
module uart_flow_fifo #(
  parameter int DEPTH  = 16,
  parameter int CTS_HI = 12,
  parameter int CTS_LO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in_data,
  input  logic                     byte_in_valid,
  output logic                     byte_in_ready,
  output logic [7:0]               byte_out_data,
  output logic                     byte_out_valid,
  input  logic                     byte_out_ready,
  input  logic                     rts_n_in,
  output logic                     cts_n_out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  typedef logic [LW-1:0] lvl_t;
  localparam lvl_t DEPTH_L = lvl_t'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  lvl_t          level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;

  logic in_fire, out_fire, ram_empty, load_ok, load_en, bypass, ram_wr, ram_rd;

  assign byte_in_ready = !rst && (level_q < DEPTH_L);
  assign in_fire       = byte_in_valid && byte_in_ready;
  assign out_fire      = out_valid_q && byte_out_ready;

  // level_q counts the output register too, so the RAM is empty when only
  // the output register (if anything) holds a byte.
  assign ram_empty = (level_q == {{PW{1'b0}}, out_valid_q});

`ifdef UART_FIFO_FLOW_CTRL_EN
  assign load_ok = !rts_n_in;
`else
  assign load_ok = 1'b1;
`endif

  // An empty RAM with a byte arriving feeds the output register directly,
  // giving one cycle of latency from input to output.
  assign load_en = (!out_valid_q || out_fire) && load_ok && (!ram_empty || in_fire);
  assign bypass  = load_en && ram_empty;
  assign ram_rd  = load_en && !ram_empty;
  assign ram_wr  = in_fire && !bypass;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (ram_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ram_rd) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({in_fire, out_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? byte_in_data : mem_q[rd_ptr_q];
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (ram_wr) mem_q[wr_ptr_q] <= byte_in_data;
  end

`ifdef UART_FIFO_FLOW_CTRL_EN
  localparam lvl_t CTS_HI_L = lvl_t'(CTS_HI);
  localparam lvl_t CTS_LO_L = lvl_t'(CTS_LO);
  logic cts_q, cts_d;

  always_comb begin
    cts_d = cts_q;
    if (level_q >= CTS_HI_L)      cts_d = 1'b1;
    else if (level_q <= CTS_LO_L) cts_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) cts_q <= 1'b0;
    else     cts_q <= cts_d;
  end

  assign cts_n_out = cts_q;
`else
  localparam int unused_cfg = CTS_HI + CTS_LO;
  logic unused_rts;
  assign unused_rts = rts_n_in;
  assign cts_n_out  = 1'b0;
`endif

  assign byte_out_valid = out_valid_q;
  assign byte_out_data  = out_data_q;
  assign level          = level_q;

endmodule

// File: tb/tb_uart_flow_fifo.sv
// Self-checking bench for uart_flow_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_flow_fifo;

  localparam int DEPTH = 16;
`ifdef UART_FIFO_FLOW_CTRL_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in_data;
  logic       byte_in_valid;
  logic       byte_in_ready;
  logic [7:0] byte_out_data;
  logic       byte_out_valid;
  logic       byte_out_ready;
  logic       rts_n_in;
  logic       cts_n_out;
  logic [4:0] level;

  int tests = 0;
  int fails = 0;

  uart_flow_fifo #(.DEPTH(DEPTH), .CTS_HI(12), .CTS_LO(4)) dut (
    .clk(clk), .rst(rst),
    .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .byte_out_data(byte_out_data), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .rts_n_in(rts_n_in), .cts_n_out(cts_n_out), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every stored byte in arrival order, plus whether the
  // head byte is currently presented on the output.
  logic [7:0] q[$];
  bit         presented = 1'b0;
  bit         m_cts = 1'b0;
  bit         model_ok = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      presented = 1'b0;
      m_cts     = 1'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      int  lvl;
      bit  in_f, out_f, rts_ok;
      lvl    = q.size();
      in_f   = byte_in_valid && (lvl < DEPTH);
      out_f  = presented && byte_out_ready;
      rts_ok = (FC == 0) || !rts_n_in;
      if (out_f) void'(q.pop_front());
      if (in_f)  q.push_back(byte_in_data);
      if (!presented || out_f) presented = (q.size() > 0) && rts_ok;
      if (FC != 0) begin
        if (lvl >= 12)     m_cts = 1'b1;
        else if (lvl <= 4) m_cts = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("level", int'(level), q.size());
      check("in_ready", int'(byte_in_ready), int'(!rst && q.size() < DEPTH));
      check("out_valid", int'(byte_out_valid), int'(presented));
      if (presented) check("out_data", int'(byte_out_data), int'(q[0]));
      check("cts_n", int'(cts_n_out), int'(m_cts));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      byte_in_valid = 1'b1;
      byte_in_data  = 8'(base + i);
      tick();
    end
    byte_in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    byte_out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    byte_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; byte_in_data = 8'h00; byte_in_valid = 1'b0;
    byte_out_ready = 1'b0; rts_n_in = 1'b0;
    tick(); tick();
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(byte_out_valid), 0);
    check("rst_data", int'(byte_out_data), 0);
    check("rst_cts", int'(cts_n_out), 0);
    check("rst_ready", int'(byte_in_ready), 0);
    rst = 1'b0;
    #1 check("ready_after_rst", int'(byte_in_ready), 1);

    // Single byte through an empty FIFO
    byte_in_valid = 1'b1; byte_in_data = 8'h41; byte_out_ready = 1'b1;
    tick();
    byte_in_valid = 1'b0;
    check("lat_valid", int'(byte_out_valid), 1);
    check("lat_data", int'(byte_out_data), 8'h41);
    tick();
    check("lat_level0", int'(level), 0);
    byte_out_ready = 1'b0;

    // Fill to full, 17th refused, drain in order
    push_n(16, 0);
    check("full_level", int'(level), 16);
    check("full_ready", int'(byte_in_ready), 0);
    check("full_cts", int'(cts_n_out), FC);
    byte_in_valid = 1'b1; byte_in_data = 8'hAA;
    tick();
    byte_in_valid = 1'b0;
    check("no_17th", int'(level), 16);
    byte_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", int'(byte_out_valid), 1);
      check("drain_data", int'(byte_out_data), i);
      tick();
    end
    byte_out_ready = 1'b0;
    check("drained", int'(level), 0);

    // CTS hysteresis
    push_n(12, 8'h20);
    check("cts_at12", int'(cts_n_out), 0);
    tick();
    check("cts_hi", int'(cts_n_out), FC);
    drain(7);
    check("lvl5", int'(level), 5);
    check("cts_5", int'(cts_n_out), FC);
    drain(1);
    check("cts_4_pre", int'(cts_n_out), FC);
    tick();
    check("cts_lo", int'(cts_n_out), 0);
    drain(4);
    check("cts_empty", int'(level), 0);

    // RTS pause
    push_n(3, 8'h60);
    check("rts_head", int'(byte_out_data), 8'h60);
    rts_n_in = 1'b1; byte_out_ready = 1'b1;
    tick();
    check("rts_paused", int'(byte_out_valid), 1 - FC);
    tick();
    check("rts_level", int'(level), FC ? 2 : 1);
    rts_n_in = 1'b0;
    tick();
    if (FC != 0) check("rts_resume", int'(byte_out_valid), 1);
    drain(4);

    // Continuous streaming across pointer wrap
    push_n(5, 8'h80);
    byte_in_valid = 1'b1; byte_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      byte_in_data = 8'($urandom);
      tick();
      check("stream_level", int'(level), 5);
    end
    byte_in_valid = 1'b0;
    drain(6);

    // Reset mid-operation
    push_n(7, 8'hC0);
    check("lvl7", int'(level), 7);
    rst = 1'b1;
    tick();
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_valid", int'(byte_out_valid), 0);
    check("mid_rst_cts", int'(cts_n_out), 0);
    rst = 1'b0;
    push_n(1, 8'h5A);
    check("post_rst_data", int'(byte_out_data), 8'h5A);
    drain(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode           = (i / 100) % 3;
      rst            = ($urandom_range(0, 299) == 0);
      byte_in_valid  = ($urandom_range(0, 3) != 0);
      byte_in_data   = 8'($urandom);
      byte_out_ready = (mode == 0) ? ($urandom_range(0, 3) == 0) :
                       (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      rts_n_in       = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0; byte_in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
